// File: rtl/status_reg_if.sv
// rtl/status_reg_if.sv - ALU/sequencer side bundle of the 6502 status register
interface status_reg_if;
    logic       alu_zero;
    logic       alu_negative;
    logic       alu_overflow;
    logic       alu_c_out;
    logic [7:0] alu_mask;
    logic [7:0] set_mask;
    logic [7:0] clr_mask;
    logic       load_p;
    logic       bit_test;
    logic [7:0] data_in;
    logic       b_push;
    logic [2:0] branch_cond;
    logic       instr_done;
    logic       irq_req;
    logic [7:0] p_out;
    logic       c_to_alu;
    logic       bcd_to_alu;
    logic       branch_taken;
    logic       irq_pending;

    modport master (
        output alu_zero, alu_negative, alu_overflow, alu_c_out,
        output alu_mask, set_mask, clr_mask, load_p, bit_test, data_in,
        output b_push, branch_cond, instr_done, irq_req,
        input  p_out, c_to_alu, bcd_to_alu, branch_taken, irq_pending
    );

    modport slave (
        input  alu_zero, alu_negative, alu_overflow, alu_c_out,
        input  alu_mask, set_mask, clr_mask, load_p, bit_test, data_in,
        input  b_push, branch_cond, instr_done, irq_req,
        output p_out, c_to_alu, bcd_to_alu, branch_taken, irq_pending
    );
endinterface

// File: rtl/status_reg.sv
// rtl/status_reg.sv - 6502 processor status register with branch and IRQ gating
module status_reg #(
    parameter logic RESET_I = 1'b1,
    parameter logic RESET_D = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    status_reg_if.slave bus
);
    // Bits 5 and 4 of P have no storage; every mask is trimmed to the six real flags.
    localparam logic [7:0] FLAG_BITS = 8'hCF;
    localparam logic [7:0] ALU_BITS  = 8'hC3;

    logic r_n, r_v, r_d, r_i, r_z, r_c;
    logic r_i_mask;
    logic r_irq_pending;

    logic [7:0] w_cur;
    logic [7:0] w_nxt;
    logic [7:0] w_alu_en;
    logic [7:0] w_alu_val;
    logic       w_flag;
    logic       w_unused_bits;

    assign w_cur     = {r_n, r_v, 2'b00, r_d, r_i, r_z, r_c};
    assign w_alu_en  = bus.alu_mask & ALU_BITS;
    assign w_alu_val = {bus.alu_negative, bus.alu_overflow, 4'b0000,
                        bus.alu_zero, bus.alu_c_out};

    always_comb begin
        w_nxt = w_cur;
        if (bus.load_p) begin
            w_nxt = bus.data_in & FLAG_BITS;
        end else begin
            w_nxt = (w_nxt & ~w_alu_en) | (w_alu_val & w_alu_en);
            if (bus.bit_test) begin
                w_nxt[7] = bus.data_in[7];
                w_nxt[6] = bus.data_in[6];
                w_nxt[1] = bus.alu_zero;
            end
            w_nxt = w_nxt & ~(bus.clr_mask & FLAG_BITS);
            w_nxt = w_nxt | (bus.set_mask & FLAG_BITS);
        end
    end

    assign w_unused_bits = &{1'b0, w_nxt[5:4]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_n           <= 1'b0;
            r_v           <= 1'b0;
            r_d           <= RESET_D;
            r_i           <= RESET_I;
            r_z           <= 1'b0;
            r_c           <= 1'b0;
            r_i_mask      <= RESET_I;
            r_irq_pending <= 1'b0;
        end else begin
            r_n <= w_nxt[7];
            r_v <= w_nxt[6];
            r_d <= w_nxt[3];
            r_i <= w_nxt[2];
            r_z <= w_nxt[1];
            r_c <= w_nxt[0];
            // IRQ masking follows I only at instruction boundaries, using the pre-update I.
            if (bus.instr_done) begin
                r_i_mask <= r_i;
            end
            r_irq_pending <= bus.irq_req & ~r_i_mask;
        end
    end

    always_comb begin
        w_flag = 1'b0;
        case (bus.branch_cond[2:1])
            2'b00:   w_flag = r_n;
            2'b01:   w_flag = r_v;
            2'b10:   w_flag = r_c;
            default: w_flag = r_z;
        endcase
    end

    assign bus.branch_taken = (w_flag == bus.branch_cond[0]);
    assign bus.p_out        = {r_n, r_v, 1'b1, bus.b_push, r_d, r_i, r_z, r_c};
    assign bus.c_to_alu     = r_c;
    assign bus.bcd_to_alu   = r_d;
    assign bus.irq_pending  = r_irq_pending;
endmodule

// File: tb/tb_status_reg.sv
// tb/tb_status_reg.sv - directed scoreboard bench for status_reg
module tb_status_reg;
    logic clk = 1'b0;
    logic reset;

    status_reg_if bus ();

    status_reg #(.RESET_I(1'b1), .RESET_D(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        n_cmp = 0;
    int        n_mis = 0;

    task automatic push(input string tag, input logic [7:0] exp);
        sb_entry_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic chk(input logic [7:0] obs);
        sb_entry_t e;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_mis++;
            $display("FAIL scoreboard_empty obs=%h exp=none", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp)
            else begin
                n_mis++;
                $error("FAIL %s obs=%h exp=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic idle_inputs();
        bus.alu_zero     = 1'b0;
        bus.alu_negative = 1'b0;
        bus.alu_overflow = 1'b0;
        bus.alu_c_out    = 1'b0;
        bus.alu_mask     = 8'h00;
        bus.set_mask     = 8'h00;
        bus.clr_mask     = 8'h00;
        bus.load_p       = 1'b0;
        bus.bit_test     = 1'b0;
        bus.data_in      = 8'h00;
        bus.instr_done   = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle_inputs();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset           = 1'b1;
        idle_inputs();
        bus.b_push      = 1'b0;
        bus.branch_cond = 3'b000;
        bus.irq_req     = 1'b0;
        bus.set_mask    = 8'hFF;
        bus.alu_mask    = 8'hFF;
        bus.alu_c_out   = 1'b1;
        step();

        push("reset_p", 8'h24);             chk(bus.p_out);
        push("reset_c", 8'h00);             chk({7'd0, bus.c_to_alu});
        push("reset_bcd", 8'h00);           chk({7'd0, bus.bcd_to_alu});
        push("reset_irq", 8'h00);           chk({7'd0, bus.irq_pending});
        bus.b_push = 1'b1; #1;
        push("reset_p_bpush", 8'h34);       chk(bus.p_out);
        bus.b_push = 1'b0;

        bus.alu_mask = 8'h83; bus.alu_negative = 1'b1; bus.alu_zero = 1'b0;
        bus.alu_c_out = 1'b1; bus.alu_overflow = 1'b1;
        push("alu_nzc", 8'hA5);
        step();                             chk(bus.p_out);

        bus.clr_mask = 8'h01;
        push("clc", 8'hA4);
        step();                             chk(bus.p_out);

        bus.set_mask = 8'h01; bus.clr_mask = 8'h01; bus.alu_mask = 8'h01; bus.alu_c_out = 1'b0;
        push("set_wins_c", 8'h01);
        step();                             chk({7'd0, bus.c_to_alu});

        push("hold", 8'hA5);
        step();                             chk(bus.p_out);

        bus.load_p = 1'b1; bus.data_in = 8'hFF; bus.clr_mask = 8'hFF;
        push("plp_ff", 8'hEF);
        push("plp_c", 8'h01);
        push("plp_bcd", 8'h01);
        step();
        chk(bus.p_out);
        chk({7'd0, bus.c_to_alu});
        chk({7'd0, bus.bcd_to_alu});
        bus.branch_cond = 3'b100; #1;
        push("bcc", 8'h00);                 chk({7'd0, bus.branch_taken});
        bus.branch_cond = 3'b101; #1;
        push("bcs", 8'h01);                 chk({7'd0, bus.branch_taken});

        bus.bit_test = 1'b1; bus.data_in = 8'h40; bus.alu_zero = 1'b1;
        push("bit_40", 8'h6F);
        step();                             chk(bus.p_out);
        bus.branch_cond = 3'b011; #1;
        push("bvs", 8'h01);                 chk({7'd0, bus.branch_taken});
        bus.branch_cond = 3'b111; #1;
        push("beq", 8'h01);                 chk({7'd0, bus.branch_taken});
        bus.branch_cond = 3'b001; #1;
        push("bmi", 8'h00);                 chk({7'd0, bus.branch_taken});

        bus.clr_mask = 8'hFF; bus.set_mask = 8'h04;
        push("clear_all_sei", 8'h24);
        step();                             chk(bus.p_out);

        bus.irq_req = 1'b1;
        push("irq_masked", 8'h00);
        step();                             chk({7'd0, bus.irq_pending});
        bus.clr_mask = 8'h04;
        push("cli_no_irq", 8'h00);
        step();                             chk({7'd0, bus.irq_pending});
        for (int k = 0; k < 3; k++) begin
            push("cli_wait", 8'h00);
            step();                         chk({7'd0, bus.irq_pending});
        end
        bus.instr_done = 1'b1;
        push("done_edge", 8'h00);
        step();                             chk({7'd0, bus.irq_pending});
        push("irq_rise", 8'h01);
        step();                             chk({7'd0, bus.irq_pending});

        bus.irq_req = 1'b0;
        push("irq_drop", 8'h00);
        step();                             chk({7'd0, bus.irq_pending});
        bus.irq_req = 1'b1;
        push("irq_back", 8'h01);
        step();                             chk({7'd0, bus.irq_pending});

        bus.set_mask = 8'h04; bus.instr_done = 1'b1;
        push("sei_done_old_i", 8'h01);
        step();                             chk({7'd0, bus.irq_pending});
        push("sei_still", 8'h01);
        step();                             chk({7'd0, bus.irq_pending});
        bus.instr_done = 1'b1;
        push("sei_done2", 8'h01);
        step();                             chk({7'd0, bus.irq_pending});
        push("sei_masked", 8'h00);
        step();                             chk({7'd0, bus.irq_pending});

        bus.clr_mask = 8'h04; bus.instr_done = 1'b1;
        step();
        push("pending_again", 8'h00);
        step();                             chk({7'd0, bus.irq_pending});
        bus.instr_done = 1'b1;
        step();
        push("pending_set", 8'h01);
        step();                             chk({7'd0, bus.irq_pending});
        reset = 1'b1; bus.load_p = 1'b1; bus.data_in = 8'hFF;
        push("reset_irq_clr", 8'h00);
        push("reset_p2", 8'h24);
        step();
        chk({7'd0, bus.irq_pending});
        chk(bus.p_out);
        push("reset_imask", 8'h00);
        step();                             chk({7'd0, bus.irq_pending});

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL scoreboard_leftover obs=%0d exp=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
